// File: rtl/dac_feeder_pkg.sv
// Shared types and constants for the DAC sample feeder.
// Optional feature macro: DAC_FEEDER_SIGNED_EN (two's complement input,
// converted to offset binary on the way to the DAC).
package dac_feeder_pkg;

   localparam int SAMPLE_W         = 12;
   localparam int FRAME_CYCLES_DEF = 17;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_FIRE  = 2'd2
   } tick_state_t;

   typedef struct packed {
      logic [SAMPLE_W-1:0] a;
      logic [SAMPLE_W-1:0] b;
   } sample_t;

   // Map a queued sample to the code the DAC expects.
   function automatic sample_t to_dac(input sample_t s);
      sample_t r;
      r = s;
`ifdef DAC_FEEDER_SIGNED_EN
      r.a[SAMPLE_W-1] = ~s.a[SAMPLE_W-1];
      r.b[SAMPLE_W-1] = ~s.b[SAMPLE_W-1];
`endif
      return r;
   endfunction

endpackage

// File: rtl/dac_sample_feeder_if.sv
// Upstream sample stream: valid/ready handshake carrying one A/B pair.
interface dac_sample_feeder_if;
   import dac_feeder_pkg::*;

   logic                s_valid;
   logic                s_ready;
   logic [SAMPLE_W-1:0] s_data_a;
   logic [SAMPLE_W-1:0] s_data_b;

   modport master (output s_valid, s_data_a, s_data_b, input s_ready);
   modport slave  (input s_valid, s_data_a, s_data_b, output s_ready);
endinterface

// File: rtl/dac_sample_feeder_sample_fifo.sv
// Synchronous FIFO of {a,b} sample words with occupancy output.
// ready is registered from the next occupancy so it is low for every cycle
// the FIFO holds DEPTH entries, even while a pop is draining it.
module sample_fifo
   import dac_feeder_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  sample_t                wdata,
   input  logic                   pop,
   output sample_t                rdata,
   output logic                   ready,
   output logic [$clog2(DEPTH):0] level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   sample_t         mem [DEPTH];
   logic [AW-1:0]   wptr, rptr;
   logic            push_ok, pop_ok;
   logic [LW-1:0]   level_nxt;

   assign push_ok   = push && ready;
   assign pop_ok    = pop && (level != '0);
   assign level_nxt = level + LW'(push_ok) - LW'(pop_ok);
   assign rdata     = mem[rptr];

   // Storage array, written on accepted pushes only.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wptr] <= wdata;
   end

   // Pointers, occupancy and registered ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
         ready <= 1'b0;
      end else begin
         if (push_ok) wptr <= wptr + 1'b1;
         if (pop_ok)  rptr <= rptr + 1'b1;
         level <= level_nxt;
         ready <= (level_nxt != LW'(DEPTH));
      end
   end
endmodule

// File: rtl/dac_sample_feeder.sv
// DAC sample feeder: buffers A/B samples and releases one pair per
// sample-rate tick to a two-channel DAC serializer.
// Optional feature macro: DAC_FEEDER_SIGNED_EN (see dac_feeder_pkg::to_dac).
module dac_sample_feeder
   import dac_feeder_pkg::*;
#(
   parameter int FIFO_DEPTH   = 8,
   parameter int FRAME_CYCLES = FRAME_CYCLES_DEF
) (
   input  logic                        clk,
   input  logic                        rst_n,
   dac_sample_feeder_if.slave          s,
   input  logic                        run,
   input  logic [15:0]                 period,
   input  logic                        underrun_clr,
   output logic                        dac_enable,
   output logic [SAMPLE_W-1:0]         dac_data_a,
   output logic [SAMPLE_W-1:0]         dac_data_b,
   output logic                        underrun,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
   tick_state_t state, state_nxt;
   logic [15:0] cnt, eff_period;
   logic        tick, load_start, load_fire, fifo_empty;
   sample_t     head, wdata, outw;

   assign eff_period = (period > 16'(FRAME_CYCLES)) ? period : 16'(FRAME_CYCLES);
   assign wdata      = '{a: s.s_data_a, b: s.s_data_b};
   assign fifo_empty = (fifo_level == '0);
   assign outw       = to_dac(head);

   sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (s.s_valid),
      .wdata (wdata),
      .pop   (tick),
      .rdata (head),
      .ready (s.s_ready),
      .level (fifo_level)
   );

   // Tick FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Tick FSM next state; dropping run always parks in IDLE.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:  if (run) state_nxt = ST_COUNT;
         ST_COUNT: if (!run) state_nxt = ST_IDLE;
                   else if (cnt == '0) state_nxt = ST_FIRE;
         ST_FIRE:  state_nxt = run ? ST_COUNT : ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Tick FSM outputs.
   always_comb begin
      tick       = (state == ST_FIRE);
      load_start = (state == ST_IDLE) && run;
      load_fire  = (state == ST_FIRE) && run;
   end

   // Interval counter. The FIRE cycle is itself one clock of the next
   // interval, so the reload from FIRE is one shorter than from IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        cnt <= '0;
      else if (load_start)               cnt <= eff_period - 16'd1;
      else if (load_fire)                cnt <= eff_period - 16'd2;
      else if (state == ST_COUNT && cnt != '0) cnt <= cnt - 16'd1;
   end

   // Output words and enable pulse; words only move on a successful tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dac_enable <= 1'b0;
         dac_data_a <= '0;
         dac_data_b <= '0;
      end else begin
         dac_enable <= tick && !fifo_empty;
         if (tick && !fifo_empty) begin
            dac_data_a <= outw.a;
            dac_data_b <= outw.b;
         end
      end
   end

   // Sticky underrun; a new event beats a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  underrun <= 1'b0;
      else if (tick && fifo_empty) underrun <= 1'b1;
      else if (underrun_clr)       underrun <= 1'b0;
   end
endmodule

// File: doc/dac_sample_feeder.md
DAC_SAMPLE_FEEDER -- requirements
Module: dac_sample_feeder

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: sample FIFO depth in entries; power of two, minimum 2.
REQ-002 Parameter FRAME_CYCLES, default 17: minimum spacing in clocks between DAC enable pulses.
REQ-003 Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
REQ-004 clk  in  1  system clock, rising-edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 s_valid  in  1  upstream sample valid.
REQ-007 s_ready  out  1  feeder can accept a sample; high when FIFO not full.
REQ-008 s_data_a  in  12  channel A sample.
REQ-009 s_data_b  in  12  channel B sample.
REQ-010 run  in  1  sample-rate ticking enabled.
REQ-011 period  in  16  sample interval in clocks.
REQ-012 underrun_clr  in  1  clears the underrun flag.
REQ-013 dac_enable  out  1  one-cycle start pulse to the two-channel DAC serializer.
REQ-014 dac_data_a  out  12  held channel A word.
REQ-015 dac_data_b  out  12  held channel B word.
REQ-016 underrun  out  1  sticky flag: a tick found the FIFO empty.
REQ-017 fifo_level  out  log2(FIFO_DEPTH)+1  current occupancy.

Function
REQ-018 Push on a rising clk edge when s_valid and s_ready are both high; fifo_level reflects the push on the next cycle.
REQ-019 s_ready SHALL be low whenever fifo_level equals FIFO_DEPTH, including cycles in which a pop occurs (no full-bypass).
REQ-020 Effective period is max(period, FRAME_CYCLES), latched at each interval reload; a period change mid-interval takes effect at the next reload.
REQ-021 Tick FSM states: IDLE (run low, counter frozen), COUNT (counter decrementing), FIRE (one cycle, tick).
REQ-022 IDLE->COUNT when run is sampled high; counter loads eff_period-1; FIRE occurs eff_period cycles after that edge.
REQ-023 FIRE->COUNT with counter reloaded, giving exactly eff_period clocks between consecutive ticks while run stays high.
REQ-024 Deasserting run in COUNT or FIRE returns to IDLE on the next edge; FIFO contents and outputs are held.
REQ-025 At a tick with FIFO non-empty: pop the head; on the same edge register it into dac_data_a/b and pulse dac_enable high for one cycle.
REQ-026 At a tick with FIFO empty: no pulse, dac_data_a/b unchanged, underrun set; a push in that same cycle is not bypassed to the output.
REQ-027 dac_data_a/b SHALL remain stable from a dac_enable pulse until the next pulse, which is at least FRAME_CYCLES later.
REQ-028 underrun_clr clears underrun; when clr coincides with a new underrun event, set wins.

Reset
REQ-029 While rst_n is low: FIFO empty, fifo_level 0, s_ready 0, dac_enable 0, dac_data_a/b 0, underrun 0, FSM in IDLE.
REQ-030 Reset asserted mid-interval aborts the interval; s_ready rises on the first clk edge after rst_n deasserts.

Configuration
REQ-031 Macro DAC_FEEDER_SIGNED_EN defined: s_data_a/b are two's complement, and bit 11 is inverted on pop so the DAC receives offset binary.
REQ-032 Macro DAC_FEEDER_SIGNED_EN undefined: samples pass unmodified as unsigned straight binary.

Structure
REQ-033 Package dac_feeder_pkg holds SAMPLE_W=12, FRAME_CYCLES_DEF=17, and the tick FSM state enum.
REQ-034 Sub-module sample_fifo: synchronous FIFO of 24-bit {a,b} words with level output; the tick FSM and output registers stay in the top module.

Verification
REQ-035 Push 3 samples (0x123/0x456, 0x789/0xABC, 0xFFF/0x000), period=20, run=1 -> three dac_enable pulses 20 clocks apart, with outputs matching in order.
REQ-036 period=5, one sample queued -> consecutive ticks spaced 17 clocks.
REQ-037 Push 8 samples with run=0 -> s_ready low at level 8; a 9th s_valid is not accepted; level stays 8.
REQ-038 Empty FIFO, run=1, period=17 -> no pulse, underrun=1 at first tick; dac_data unchanged; underrun_clr returns it to 0.
REQ-039 rst_n pulsed low mid-interval with 4 entries queued -> level 0, outputs 0, no pulse until run resamples and a full period elapses.
REQ-040 With DAC_FEEDER_SIGNED_EN, push A=0x800 (-2048), B=0x7FF -> dac_data_a=0x000, dac_data_b=0xFFF.
